// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ byte sources.
// Frames are 8N1/8N2, paced by rising edges of the same-domain baud square wave.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int OVERSAMPLING = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       baud_clk_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       tx_out,
    output logic                       busy_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_out
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(OVERSAMPLING);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ALIGN,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            baud_prev_q;

    logic            tick;
    logic            bit_end;
    logic            rr_found;
    logic [GW-1:0]   rr_idx;
    logic [GW-1:0]   rr_cand;

    assign tick    = baud_clk_in & ~baud_prev_q;
    assign bit_end = tick && (tick_cnt_q == TICK_LAST);

    // Search upward from last_grant+1, wrapping, and keep the first hit.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rr_cand = GW'((32'(last_q) + i + 32'd1) % 32'(NUM_REQ));
            if (!rr_found && req_valid_in[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            grant_q     <= '0;
            last_q      <= GW'(NUM_REQ - 1);
            baud_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            baud_prev_q <= baud_clk_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        grant_d    = grant_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    last_d  = rr_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                shift_d = req_data_in[{grant_q, 3'b000} +: 8];
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (tick) begin
                    tick_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START, S_DATA, S_STOP: begin
                if (tick) begin
                    tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
                end
                if (bit_end) begin
                    case (state_q)
                        S_START: begin
                            bit_cnt_d = '0;
                            state_d   = S_DATA;
                        end
                        S_DATA: begin
                            shift_d = {1'b0, shift_q[7:1]};
                            if (bit_cnt_q == 3'd7) begin
                                stop_cnt_d = 1'b0;
                                state_d    = S_STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                        default: begin
                            if (stop_cnt_q == STOP_LAST) begin
                                state_d = S_IDLE;
                            end else begin
                                stop_cnt_d = stop_cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_out = '0;
        tx_out        = 1'b1;
        busy_out      = (state_q != S_IDLE);
        grant_idx_out = grant_q;
        case (state_q)
            S_GRANT: req_ready_out[grant_q] = 1'b1;
            S_START: tx_out = 1'b0;
            S_DATA:  tx_out = shift_q[0];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a table of frames plus hand-written
// mid-frame reset and two-stop-bit sequences; baud wave rises every 4 clocks.
module tb_uart_tx_scheduler;
    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        baud = 1'b0;

    logic [3:0]  valid = '0;
    logic [31:0] data  = '0;
    logic [3:0]  ready;
    logic        tx, busy;
    logic [1:0]  gidx;

    logic [3:0]  valid2 = '0;
    logic [31:0] data2  = '0;
    logic [3:0]  ready2;
    logic        tx2, busy2;
    logic [1:0]  gidx2;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(.NUM_REQ(4), .OVERSAMPLING(8), .STOP_BITS(1)) dut (
        .clk_in(clk), .rst_in(rst), .baud_clk_in(baud),
        .req_valid_in(valid), .req_data_in(data), .req_ready_out(ready),
        .tx_out(tx), .busy_out(busy), .grant_idx_out(gidx)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .OVERSAMPLING(8), .STOP_BITS(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .baud_clk_in(baud),
        .req_valid_in(valid2), .req_data_in(data2), .req_ready_out(ready2),
        .tx_out(tx2), .busy_out(busy2), .grant_idx_out(gidx2)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (2) @(negedge clk);
            baud = ~baud;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          do_reset;
        logic [3:0]  add;
        logic [3:0]  mid;
        logic [3:0]  keep;
        logic [31:0] data;
        int          exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks every clock of a frame against the expected line level and busy,
    // decodes the byte at mid-bit, then checks busy has fallen exactly at frame end.
    task automatic check_frame(input int sel, input logic [7:0] b, input int nstop,
                               input logic [3:0] mid);
        int         nbits = 9 + nstop;
        logic [11:0] bits = '1;
        int         errs  = 0;
        int         waitn = 0;
        logic [7:0] rx    = '0;
        logic       txv;
        logic       bv;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = b[k];
        while (((sel != 0) ? tx2 : tx) !== 1'b0 && waitn < 40) begin
            @(negedge clk);
            waitn++;
        end
        txv = (sel != 0) ? tx2 : tx;
        chk("start_edge", {31'b0, txv}, 32'd0);
        if (txv !== 1'b0) return;
        valid = valid | mid;
        for (int n = 0; n < nbits * 32; n++) begin
            txv = (sel != 0) ? tx2 : tx;
            bv  = (sel != 0) ? busy2 : busy;
            if (txv !== bits[n/32] || bv !== 1'b1) errs++;
            if (n % 32 == 16 && n / 32 >= 1 && n / 32 <= 8) rx[n/32-1] = txv;
            @(negedge clk);
        end
        chk("frame_shape_errs", errs, 0);
        chk("rx_byte", {24'b0, rx}, {24'b0, b});
        chk("busy_fall", {31'b0, (sel != 0) ? busy2 : busy}, 32'd0);
    endtask

    task automatic do_frame(input vec_t v);
        int w = 0;
        if (v.do_reset) pulse_reset();
        valid = valid | v.add;
        data  = v.data;
        while (ready === 4'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_onehot", 32'($onehot(ready)), 32'd1);
        chk("ready_idx", {28'b0, ready}, 32'd1 << v.exp_grant);
        chk("grant_idx", {30'b0, gidx}, 32'(v.exp_grant));
        chk("busy_at_grant", {31'b0, busy}, 32'd1);
        valid = valid & ~(ready & ~v.keep);
        @(negedge clk);
        chk("ready_single_cycle", {28'b0, ready}, 32'd0);
        check_frame(0, v.exp_byte, 1, v.mid);
    endtask

    initial begin
        vec_t hv;
        int   w;
        //             rst  add      mid      keep     data           grant byte
        vecs[0] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h1312_1110, 0, 8'h10};
        vecs[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h1312_1110, 1, 8'h11};
        vecs[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h1312_1110, 2, 8'h12};
        vecs[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h1312_1110, 3, 8'h13};
        vecs[5] = '{1'b0, 4'b0001, 4'b1000, 4'b0001, 32'h3300_0055, 0, 8'h55};
        vecs[6] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h3300_0055, 3, 8'h33};
        vecs[7] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h3300_0055, 0, 8'h55};

        repeat (3) @(negedge clk);
        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ready", {28'b0, ready}, 32'd0);
        chk("reset_grant", {30'b0, gidx}, 32'd0);
        chk("reset_tx2", {31'b0, tx2}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_frame(vecs[i]);

        // Reset during data bit 4 of a frame from requester 2.
        valid = 4'b0100;
        data  = 32'h005A_0000;
        w = 0;
        while (ready === 4'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("mr_ready", {28'b0, ready}, 32'h4);
        valid = 4'b0000;
        w = 0;
        while (tx !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        repeat (5 * 32 + 10) @(negedge clk);
        chk("mr_busy_before", {31'b0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_tx", {31'b0, tx}, 32'd1);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_ready_low", {28'b0, ready}, 32'd0);
        chk("mr_grant", {30'b0, gidx}, 32'd0);
        valid = 4'b0011;
        data  = 32'h0000_2211;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hv = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_2211, 0, 8'h11};
        do_frame(hv);
        hv = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_2211, 1, 8'h22};
        do_frame(hv);

        // Two stop bits: 0xFF gives 32 clocks low then 320 clocks high.
        valid2 = 4'b0001;
        data2  = 32'h0000_00FF;
        w = 0;
        while (ready2 === 4'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("sb2_ready", {28'b0, ready2}, 32'h1);
        chk("sb2_grant", {30'b0, gidx2}, 32'd0);
        valid2 = 4'b0000;
        check_frame(1, 8'hFF, 2, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
